// File: rtl/mc_sequencer.sv
// Multicycle MIPS-subset control sequencer: Moore FSM producing datapath
// enables/selects, with memory wait-timeout and sticky illegal/bus error flags.
module mc_sequencer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       iord,
   output logic       alusrca,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state,
   output logic       illegal,
   output logic       bus_err
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
      S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
      S_ERROR   = 4'd15
   } state_t;

   localparam int WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t            state_r, next_s;
   logic [WAIT_W-1:0] wait_r, wait_next_s;
   logic              illegal_r, bus_err_r;
   logic              mem_state_s, timeout_s, funct_ok_s, next_is_mem_s;
   logic [2:0]        funct_alu_s;
   logic              pcen_s, irwrite_s, regwrite_s, memwrite_s;

   assign mem_state_s   = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
   assign next_is_mem_s = (next_s == S_FETCH) || (next_s == S_MEMRD) || (next_s == S_MEMWR);
   // The limit cycle itself is still tolerated; only a further low cycle times out.
   assign timeout_s     = mem_state_s && !mem_ready && (wait_r == WAIT_MAX);

   // R-type function legality and ALU operation decode
   always_comb begin
      funct_ok_s  = 1'b1;
      funct_alu_s = 3'b010;
      case (funct)
         6'b100000: funct_alu_s = 3'b010;
         6'b100010: funct_alu_s = 3'b110;
         6'b100100: funct_alu_s = 3'b000;
         6'b100101: funct_alu_s = 3'b001;
         6'b101010: funct_alu_s = 3'b111;
         default:   funct_ok_s  = 1'b0;
      endcase
   end

   // Next-state selection
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_FETCH:   if (timeout_s) next_s = S_ERROR;
                    else if (mem_ready) next_s = S_DECODE;
                    else next_s = S_FETCH;
         S_DECODE:  case (op)
                       OP_LW, OP_SW: next_s = S_MEMADR;
                       OP_RTYPE:     if (funct_ok_s) next_s = S_EXECUTE;
                                     else next_s = S_ERROR;
                       OP_BEQ:       next_s = S_BRANCH;
                       OP_ADDI:      next_s = S_ADDIEX;
                       OP_J:         next_s = S_JUMP;
                       default:      next_s = S_ERROR;
                    endcase
         S_MEMADR:  if (op == OP_LW) next_s = S_MEMRD;
                    else if (op == OP_SW) next_s = S_MEMWR;
                    else next_s = S_ERROR;
         S_MEMRD:   if (timeout_s) next_s = S_ERROR;
                    else if (mem_ready) next_s = S_MEMWB;
                    else next_s = S_MEMRD;
         S_MEMWR:   if (timeout_s) next_s = S_ERROR;
                    else if (mem_ready) next_s = S_FETCH;
                    else next_s = S_MEMWR;
         S_EXECUTE: next_s = S_ALUWB;
         S_ADDIEX:  next_s = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: next_s = S_FETCH;
         S_ERROR:   next_s = S_ERROR;
         default:   next_s = S_ERROR;
      endcase
   end

   // Saturating memory wait counter, cleared on entry to a memory state
   always_comb begin
      if ((next_s != state_r) && next_is_mem_s) begin
         wait_next_s = {WAIT_W{1'b0}};
      end else if (mem_state_s && !mem_ready && (wait_r != WAIT_MAX)) begin
         wait_next_s = wait_r + WAIT_W'(1);
      end else begin
         wait_next_s = wait_r;
      end
   end

   // State, wait counter and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_FETCH;
         wait_r    <= {WAIT_W{1'b0}};
         illegal_r <= 1'b0;
         bus_err_r <= 1'b0;
      end else begin
         state_r   <= next_s;
         wait_r    <= wait_next_s;
         illegal_r <= illegal_r | ((state_r == S_DECODE) && (next_s == S_ERROR));
         bus_err_r <= bus_err_r | timeout_s;
      end
   end

   // Moore output decode; FETCH and BRANCH enables follow mem_ready / zero
   always_comb begin
      pcen_s     = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      memwrite_s = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b010;
      case (state_r)
         S_FETCH:   begin alusrcb = 2'b01; irwrite_s = mem_ready; pcen_s = mem_ready; end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB:   begin memtoreg = 1'b1; regwrite_s = 1'b1; end
         S_MEMWR:   begin iord = 1'b1; memwrite_s = 1'b1; end
         S_EXECUTE: begin alusrca = 1'b1; alucontrol = funct_alu_s; end
         S_ALUWB:   begin regdst = 1'b1; regwrite_s = 1'b1; end
         S_BRANCH:  begin alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01; pcen_s = zero; end
         S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         S_ADDIWB:  regwrite_s = 1'b1;
         S_JUMP:    begin pcsrc = 2'b10; pcen_s = 1'b1; end
         default:   pcen_s = 1'b0;
      endcase
   end

   // Write enables are forced low for as long as rst is held.
   assign pcen     = pcen_s & ~rst;
   assign irwrite  = irwrite_s & ~rst;
   assign regwrite = regwrite_s & ~rst;
   assign memwrite = memwrite_s & ~rst;
   assign state    = state_r;
   assign illegal  = illegal_r;
   assign bus_err  = bus_err_r;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed scenarios plus randomized
// instruction streams checked against a trace-level reference model.
module tb_mc_sequencer;

   localparam int LIMIT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic       illegal, bus_err;
   logic [14:0] act_ctl;

   int n_tests = 0;
   int n_fail  = 0;

   mc_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
      .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
      .state(state), .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   assign act_ctl = {pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg,
                     alusrcb, pcsrc, alucontrol};

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic       zr;
      logic       ill;
      logic       berr;
      logic [5:0] op;
      logic [5:0] fn;
   } step_t;

   step_t      tr[$];
   logic       ill_m, berr_m, dead;
   logic [5:0] cur_op, cur_fn;

   function automatic logic [14:0] exp_ctl(input logic [3:0] st, input logic mr,
                                           input logic zr, input logic [5:0] fn);
      logic pc, irw, rw, mw, io, asa, rd, m2r;
      logic [1:0] asb, ps;
      logic [2:0] ac;
      {pc, irw, rw, mw, io, asa, rd, m2r} = 8'd0;
      asb = 2'b00; ps = 2'b00; ac = 3'b010;
      case (st)
         4'd0:  begin asb = 2'b01; irw = mr; pc = mr; end
         4'd1:  asb = 2'b11;
         4'd2:  begin asa = 1'b1; asb = 2'b10; end
         4'd3:  io = 1'b1;
         4'd4:  begin m2r = 1'b1; rw = 1'b1; end
         4'd5:  begin io = 1'b1; mw = 1'b1; end
         4'd6:  begin
                   asa = 1'b1;
                   case (fn)
                      6'b100010: ac = 3'b110;
                      6'b100100: ac = 3'b000;
                      6'b100101: ac = 3'b001;
                      6'b101010: ac = 3'b111;
                      default:   ac = 3'b010;
                   endcase
                end
         4'd7:  begin rd = 1'b1; rw = 1'b1; end
         4'd8:  begin asa = 1'b1; ac = 3'b110; ps = 2'b01; pc = zr; end
         4'd9:  begin asa = 1'b1; asb = 2'b10; end
         4'd10: rw = 1'b1;
         4'd11: begin ps = 2'b10; pc = 1'b1; end
         default: pc = 1'b0;
      endcase
      return {pc, irw, rw, mw, io, asa, rd, m2r, asb, ps, ac};
   endfunction

   function automatic logic funct_legal(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic logic op_legal(input logic [5:0] o);
      return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   task automatic push(input logic [3:0] st, input logic mr);
      step_t s;
      s.st = st; s.mr = mr; s.zr = 1'($urandom_range(0, 1));
      s.ill = ill_m; s.berr = berr_m; s.op = cur_op; s.fn = cur_fn;
      tr.push_back(s);
   endtask

   // A memory state waits 'waits' low cycles then completes; beyond LIMIT it times out.
   task automatic push_mem(input logic [3:0] st, input int waits);
      if (waits > LIMIT) begin
         for (int i = 0; i <= LIMIT; i++) push(st, 1'b0);
         berr_m = 1'b1;
         dead   = 1'b1;
      end else begin
         for (int i = 0; i < waits; i++) push(st, 1'b0);
         push(st, 1'b1);
      end
   endtask

   task automatic push_instr(input int kind, input int wf, input int wm);
      logic [5:0] v;
      logic [5:0] good_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      cur_fn = 6'($urandom_range(0, 63));
      case (kind)
         0: cur_op = 6'b100011;
         1: cur_op = 6'b101011;
         2: begin cur_op = 6'b000000; cur_fn = good_fn[$urandom_range(0, 4)]; end
         3: cur_op = 6'b000100;
         4: cur_op = 6'b001000;
         5: cur_op = 6'b000010;
         6: begin
               do v = 6'($urandom_range(0, 63)); while (op_legal(v));
               cur_op = v;
            end
         default: begin
               cur_op = 6'b000000;
               do v = 6'($urandom_range(0, 63)); while (funct_legal(v));
               cur_fn = v;
            end
      endcase
      push_mem(4'd0, wf);
      if (!dead) begin
         push(4'd1, 1'($urandom_range(0, 1)));
         case (kind)
            0: begin
                  push(4'd2, 1'($urandom_range(0, 1)));
                  push_mem(4'd3, wm);
                  if (!dead) push(4'd4, 1'($urandom_range(0, 1)));
               end
            1: begin
                  push(4'd2, 1'($urandom_range(0, 1)));
                  push_mem(4'd5, wm);
               end
            2: begin push(4'd6, 1'($urandom_range(0, 1))); push(4'd7, 1'($urandom_range(0, 1))); end
            3: push(4'd8, 1'($urandom_range(0, 1)));
            4: begin push(4'd9, 1'($urandom_range(0, 1))); push(4'd10, 1'($urandom_range(0, 1))); end
            5: push(4'd11, 1'($urandom_range(0, 1)));
            default: begin ill_m = 1'b1; dead = 1'b1; end
         endcase
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; funct = 6'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      mem_ready = 1'b1;
      #1;
      n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
      n_tests++; if ({illegal, bus_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {illegal, bus_err}); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL async_reset_state got %0d want 0", state); end
      n_tests++; if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin n_fail++; $display("FAIL reset_we got %b want 0000", {pcen, irwrite, regwrite, memwrite}); end
      @(negedge clk);
      n_tests++; if ({pcen, irwrite, state} !== 6'd0) begin n_fail++; $display("FAIL reset_hold got %b want 0", {pcen, irwrite, state}); end
      // reset abandons a store in progress
      do_reset();
      op = 6'b101011; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_tests++; if ({state, memwrite} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL sw_reach got %0d/%b want 5/1", state, memwrite); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if ({state, memwrite} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL sw_abort got %0d/%b want 0/0", state, memwrite); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lw();
      logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      do_reset();
      op = 6'b100011; mem_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_tests++; if (state !== exp_st[c]) begin n_fail++; $display("FAIL lw_state c%0d got %0d want %0d", c, state, exp_st[c]); end
         n_tests++; if ({regwrite, memtoreg} !== {2{c == 4}}) begin n_fail++; $display("FAIL lw_wb c%0d got %b", c, {regwrite, memtoreg}); end
         @(negedge clk);
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         do_reset();
         op = 6'b000100; mem_ready = 1'b1; zero = 1'(z);
         repeat (2) @(negedge clk);
         #1;
         n_tests++; if ({state, pcsrc, pcen} !== {4'd8, 2'b01, 1'(z)}) begin n_fail++; $display("FAIL beq_z%0d got st%0d pcsrc%b pcen%b", z, state, pcsrc, pcen); end
         @(negedge clk);
         #1;
         n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL beq_ret_z%0d got %0d want 0", z, state); end
      end
   endtask

   task automatic test_sw_wait();
      logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
      int mw_cycles = 0;
      do_reset();
      op = 6'b101011;
      for (int c = 0; c < 8; c++) begin
         mem_ready = !(c >= 3 && c <= 5);
         #1;
         if (memwrite === 1'b1) mw_cycles++;
         n_tests++; if (state !== exp_st[c]) begin n_fail++; $display("FAIL sw_state c%0d got %0d want %0d", c, state, exp_st[c]); end
         n_tests++; if ({memwrite, regwrite} !== {exp_st[c] == 4'd5, 1'b0}) begin n_fail++; $display("FAIL sw_we c%0d got %b", c, {memwrite, regwrite}); end
         @(negedge clk);
      end
      n_tests++; if (mw_cycles != 4) begin n_fail++; $display("FAIL sw_mw_count got %0d want 4", mw_cycles); end
   endtask

   task automatic test_illegal();
      do_reset();
      op = 6'b111111; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         #1;
         n_tests++; if ({state, illegal, bus_err} !== {4'd15, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ill_state c%0d got st%0d ill%b be%b", c, state, illegal, bus_err); end
         n_tests++; if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin n_fail++; $display("FAIL ill_we c%0d got %b", c, {pcen, irwrite, regwrite, memwrite}); end
         @(negedge clk);
      end
      do_reset();
      #1;
      n_tests++; if ({state, illegal} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL ill_clear got st%0d ill%b", state, illegal); end
   endtask

   task automatic test_timeout();
      do_reset();
      op = 6'b100011; mem_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_tests++; if ({state, bus_err} !== ((c < 5) ? {4'd0, 1'b0} : {4'd15, 1'b1})) begin n_fail++; $display("FAIL timeout c%0d got st%0d be%b", c, state, bus_err); end
         n_tests++; if (irwrite !== 1'b0) begin n_fail++; $display("FAIL timeout_irw c%0d got %b want 0", c, irwrite); end
         @(negedge clk);
      end
      // ready arriving on the limit cycle completes normally
      do_reset();
      for (int c = 0; c < 6; c++) begin
         mem_ready = (c == 4);
         #1;
         if (c == 4) begin
            n_tests++; if ({state, irwrite} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL limit_fetch got st%0d irw%b", state, irwrite); end
         end
         if (c == 5) begin
            n_tests++; if ({state, bus_err} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL limit_ok got st%0d be%b", state, bus_err); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rtype();
      do_reset();
      op = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if ({state, alucontrol, alusrca, regwrite} !== {4'd6, 3'b111, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rt_exec got st%0d alu%b", state, alucontrol); end
      @(negedge clk);
      #1;
      n_tests++; if ({state, regdst, regwrite} !== {4'd7, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rt_wb got st%0d rd%b rw%b", state, regdst, regwrite); end
      do_reset();
      op = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests++; if ({state, regwrite} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL rt_rst got st%0d rw%b", state, regwrite); end
      @(negedge clk);
      n_tests++; if ({state, regwrite} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL rt_rst_hold got st%0d rw%b", state, regwrite); end
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if (state !== 4'd1) begin n_fail++; $display("FAIL rt_restart got %0d want 1", state); end
   endtask

   task automatic test_random();
      int n, kind, wf, wm;
      for (int run = 0; run < 40; run++) begin
         do_reset();
         ill_m = 1'b0; berr_m = 1'b0; dead = 1'b0; tr.delete();
         n = $urandom_range(1, 4);
         for (int k = 0; k < n && !dead; k++) begin
            kind = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            wf = ($urandom_range(0, 11) == 0) ? LIMIT + 1 : $urandom_range(0, LIMIT);
            wm = ($urandom_range(0, 7) == 0)  ? LIMIT + 2 : $urandom_range(0, LIMIT);
            push_instr(kind, wf, wm);
         end
         if (dead) repeat (3) push(4'd15, 1'($urandom_range(0, 1)));
         foreach (tr[i]) begin
            op = tr[i].op; funct = tr[i].fn; mem_ready = tr[i].mr; zero = tr[i].zr;
            #1;
            n_tests++; if (state !== tr[i].st) begin n_fail++; $display("FAIL rnd_state r%0d s%0d got %0d want %0d", run, i, state, tr[i].st); end
            n_tests++; if (act_ctl !== exp_ctl(tr[i].st, tr[i].mr, tr[i].zr, tr[i].fn)) begin n_fail++; $display("FAIL rnd_ctl r%0d s%0d got %b want %b", run, i, act_ctl, exp_ctl(tr[i].st, tr[i].mr, tr[i].zr, tr[i].fn)); end
            n_tests++; if ({illegal, bus_err} !== {tr[i].ill, tr[i].berr}) begin n_fail++; $display("FAIL rnd_flags r%0d s%0d got %b want %b", run, i, {illegal, bus_err}, {tr[i].ill, tr[i].berr}); end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_beq();
      test_sw_wait();
      test_illegal();
      test_timeout();
      test_rtype();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, meaning the maximum number of consecutive mem_ready-low cycles tolerated in one memory state.
REQ-002 SHALL have port clk, input, 1, the clock.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port op, input, 6, the instruction opcode field.
REQ-005 SHALL have port funct, input, 6, the R-type function field.
REQ-006 SHALL have port zero, input, 1, which is high when the ALU result equals 0.
REQ-007 SHALL have port mem_ready, input, 1, which is high when the current memory access completes this cycle.
REQ-008 SHALL have outputs pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, each 1 bit, as datapath enables and selects.
REQ-009 SHALL have outputs alusrcb (2 bits), pcsrc (2 bits) and alucontrol (3 bits).
REQ-010 SHALL have outputs state (4 bits), illegal (1 bit) and bus_err (1 bit).

Function
REQ-011 SHALL implement a Moore FSM with these state encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6
- ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=15
REQ-012 SHALL drive the state output with the current state register.
REQ-013 SHALL use these transitions:
- FETCH->DECODE when mem_ready=1.
- DECODE dispatches on op: 100011/101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP; any other op->ERROR.
- MEMADR->MEMRD for op 100011; MEMADR->MEMWR for op 101011.
- MEMRD->MEMWB when mem_ready=1; MEMWR->FETCH when mem_ready=1.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP->FETCH.
- EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-014 SHALL treat an R-type funct outside {100000, 100010, 100100, 100101, 101010} in DECODE as illegal and go to ERROR.
REQ-015 SHALL, in every state, drive each output not listed for that state as 0, with alucontrol=010.
- FETCH: alusrcb=01; irwrite=1 and pcen=1 only in cycles where mem_ready=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1 in every cycle of the state.
- EXECUTE: alusrca=1; alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, alucontrol=110, pcsrc=01, pcen=zero.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcen=1.
REQ-016 SHALL keep a wait counter with these rules:
- Cleared on entry to FETCH, MEMRD and MEMWR.
- Incremented each cycle in those states while mem_ready=0.
- Saturates, and never wraps.
REQ-017 SHALL go to ERROR and set bus_err on the cycle after the wait counter reaches WAIT_LIMIT with mem_ready still 0; a mem_ready=1 on that same limit cycle completes normally.
REQ-018 SHALL set illegal on entry to ERROR from DECODE.
REQ-019 SHALL make illegal and bus_err sticky until rst.
REQ-020 SHALL leave ERROR only through rst, with all write enables (pcen, irwrite, regwrite, memwrite) held at 0 while in ERROR.
REQ-021 SHALL assert at most one of regwrite and memwrite in any cycle.
REQ-022 SHALL assert irwrite only in FETCH.

Reset
REQ-023 SHALL, while rst=1 (asynchronously), force state=FETCH, the wait counter to 0, and illegal=0, bus_err=0.
REQ-024 SHALL, during reset, hold every write enable at 0, including during FETCH.
REQ-025 SHALL abandon any instruction in progress at rst assertion (e.g. no memwrite after rst while in MEMWR), restarting in FETCH on the first clk edge after rst falls.

Verification
REQ-026 SHALL be verified with lw, op=100011, mem_ready=1 always -> states 0,1,2,3,4,0 in 5 cycles, with regwrite=1 and memtoreg=1 only in state 4.
REQ-027 SHALL be verified with beq, op=000100, run once with zero=1 and once with zero=0 -> BRANCH shows pcsrc=01 and pcen=1 then 0 respectively, followed by FETCH.
REQ-028 SHALL be verified with sw and mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH, with regwrite never asserted.
REQ-029 SHALL be verified with op=111111 in DECODE -> state=15, illegal=1, all write enables 0 for 10 cycles; rst pulse -> state=0, illegal=0.
REQ-030 SHALL be verified with WAIT_LIMIT=4 and mem_ready held 0 in FETCH -> state=15 and bus_err=1 after 5 cycles, with irwrite never asserted.
REQ-031 SHALL be verified with R-type funct=101010 -> EXECUTE alucontrol=111, ALUWB regdst=1 and regwrite=1; asserting rst mid-EXECUTE -> state=0 immediately with no regwrite.
